// File: rtl/bam8_err_stats.sv
// Error statistics collector for an 8x8 approximate multiplier: compares each
// approximate product against the exact one and accumulates count/max/sum of error distance.
module bam8_err_stats #(
  parameter int SUM_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [15:0]      n_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  input  logic [15:0]      approx,
  output logic             busy,
  output logic             done,
  output logic [15:0]      sample_cnt,
  output logic [15:0]      err_cnt,
  output logic [15:0]      max_ed,
  output logic [SUM_W-1:0] sum_ed,
  output logic             sum_sat
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  // |exact - approx| via a 17-bit signed difference; the magnitude always fits 16 bits
  function automatic logic [15:0] abs_ed(input logic [15:0] exact, input logic [15:0] apx);
    logic signed [16:0] diff;
    logic signed [16:0] mag;
    diff = $signed({1'b0, exact}) - $signed({1'b0, apx});
    mag  = diff[16] ? -diff : diff;
    return mag[15:0];
  endfunction

  // MSB of the result flags overflow; the low SUM_W bits are already clamped to all-ones
  function automatic logic [SUM_W:0] sat_add(input logic [SUM_W-1:0] acc, input logic [15:0] ed);
    logic [SUM_W:0] s;
    s = {1'b0, acc} + {{(SUM_W-15){1'b0}}, ed};
    if (s[SUM_W]) s = {1'b1, {SUM_W{1'b1}}};
    return s;
  endfunction

  state_t            r_state, w_state_nxt;
  logic [15:0]       r_rem;
  logic              r_vld_p1, r_vld_p2;
  logic [7:0]        r_a_p1, r_b_p1;
  logic [15:0]       r_apx_p1;
  logic [15:0]       r_ed_p2;
  logic              r_err_p2;
  logic [15:0]       r_sample_cnt, r_err_cnt, r_max_ed;
  logic [SUM_W-1:0]  r_sum_ed;
  logic              r_sum_sat;

  logic              w_accept;
  logic              w_start_ok;
  logic [15:0]       w_exact_p1;
  logic [15:0]       w_ed_p1;
  logic [SUM_W:0]    w_sum_nxt;

  assign in_ready   = (r_state == S_RUN);
  assign busy       = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done       = (r_state == S_DONE);
  assign w_accept   = in_valid && in_ready;
  assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  assign sample_cnt = r_sample_cnt;
  assign err_cnt    = r_err_cnt;
  assign max_ed     = r_max_ed;
  assign sum_ed     = r_sum_ed;
  assign sum_sat    = r_sum_sat;

  // DRAIN ends on the edge that retires the last sample into the statistics
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_state_nxt = (n_samples == 16'd0) ? S_DONE : S_RUN;
      S_RUN:          if (w_accept && (r_rem == 16'd1)) w_state_nxt = S_DRAIN;
      S_DRAIN:        if (r_vld_p2 && !r_vld_p1) w_state_nxt = S_DONE;
      default:        w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_rem    <= 16'd0;
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      if (w_start_ok)    r_rem <= n_samples;
      else if (w_accept) r_rem <= r_rem - 16'd1;
      r_vld_p1 <= w_accept;
      r_vld_p2 <= r_vld_p1;
    end
  end

  // Stage 1: capture operands on acceptance
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a_p1   <= a;
      r_b_p1   <= b;
      r_apx_p1 <= approx;
    end
  end

  // Stage 2: exact product and error distance
  assign w_exact_p1 = {8'd0, r_a_p1} * {8'd0, r_b_p1};
  assign w_ed_p1    = abs_ed(w_exact_p1, r_apx_p1);

  always_ff @(posedge clk) begin
    if (r_vld_p1) begin
      r_ed_p2  <= w_ed_p1;
      r_err_p2 <= (w_ed_p1 != 16'd0);
    end
  end

  // Stage 3: statistics accumulation
  assign w_sum_nxt = sat_add(r_sum_ed, r_ed_p2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sample_cnt <= 16'd0;
      r_err_cnt    <= 16'd0;
      r_max_ed     <= 16'd0;
      r_sum_ed     <= '0;
      r_sum_sat    <= 1'b0;
    end else if (w_start_ok) begin
      r_sample_cnt <= 16'd0;
      r_err_cnt    <= 16'd0;
      r_max_ed     <= 16'd0;
      r_sum_ed     <= '0;
      r_sum_sat    <= 1'b0;
    end else if (r_vld_p2) begin
      r_sample_cnt <= r_sample_cnt + 16'd1;
      r_err_cnt    <= r_err_cnt + {15'd0, r_err_p2};
      if (r_ed_p2 > r_max_ed) r_max_ed <= r_ed_p2;
      r_sum_ed     <= w_sum_nxt[SUM_W-1:0];
      r_sum_sat    <= r_sum_sat | w_sum_nxt[SUM_W];
    end
  end

endmodule

// File: tb/tb_bam8_err_stats.sv
// Randomized scoreboard bench for bam8_err_stats: a 32-bit and a 17-bit accumulator
// instance share stimulus; final statistics of each run are checked when done rises.
module tb_bam8_err_stats;

  logic        clk = 1'b0;
  logic        rst, start, in_valid;
  logic [15:0] n_samples, approx;
  logic [7:0]  a, b;

  logic        in_ready, busy, done, sum_sat;
  logic [15:0] sample_cnt, err_cnt, max_ed;
  logic [31:0] sum_ed;
  logic        in_ready17, busy17, done17, sum_sat17;
  logic [15:0] sample_cnt17, err_cnt17, max_ed17;
  logic [16:0] sum_ed17;

  always #5 clk = ~clk;

  bam8_err_stats #(.SUM_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .n_samples(n_samples),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .approx(approx),
    .busy(busy), .done(done), .sample_cnt(sample_cnt), .err_cnt(err_cnt),
    .max_ed(max_ed), .sum_ed(sum_ed), .sum_sat(sum_sat)
  );

  bam8_err_stats #(.SUM_W(17)) dut17 (
    .clk(clk), .rst(rst), .start(start), .n_samples(n_samples),
    .in_valid(in_valid), .in_ready(in_ready17), .a(a), .b(b), .approx(approx),
    .busy(busy17), .done(done17), .sample_cnt(sample_cnt17), .err_cnt(err_cnt17),
    .max_ed(max_ed17), .sum_ed(sum_ed17), .sum_sat(sum_sat17)
  );

  typedef struct {
    int     cnt;
    int     err;
    int     mx;
    longint sum32;
    int     sat32;
    longint sum17;
    int     sat17;
  } exp_t;

  int     n_vec = 0;
  int     n_err = 0;
  int     sa[64], sb[64], sap[64];
  exp_t   sb_q[$];
  exp_t   mon_e;
  bit     armed = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic over the whole run, saturation as a clamp of the total
  function automatic exp_t model(input int n);
    exp_t   e;
    longint tot = 0;
    int     p, ed;
    e.cnt = n; e.err = 0; e.mx = 0;
    for (int i = 0; i < n; i++) begin
      p  = sa[i] * sb[i];
      ed = (p > sap[i]) ? p - sap[i] : sap[i] - p;
      if (ed != 0) e.err++;
      if (ed > e.mx) e.mx = ed;
      tot += ed;
    end
    e.sat32 = (tot > 64'd4294967295) ? 1 : 0;
    e.sum32 = e.sat32 ? 64'd4294967295 : tot;
    e.sat17 = (tot > 131071) ? 1 : 0;
    e.sum17 = e.sat17 ? 131071 : tot;
    return e;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_sample_cnt"}, sample_cnt, 0);
    chk({tag, "_err_cnt"}, err_cnt, 0);
    chk({tag, "_max_ed"}, max_ed, 0);
    chk({tag, "_sum_ed"}, sum_ed, 0);
    chk({tag, "_sum_sat"}, sum_sat, 0);
    chk({tag, "_busy17"}, busy17, 0);
    chk({tag, "_sum_ed17"}, sum_ed17, 0);
    chk({tag, "_sample_cnt17"}, sample_cnt17, 0);
  endtask

  // Monitor: arm when a start will be accepted, compare final stats once done is seen
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        armed = 1'b0;
      end else begin
        if (armed && done) begin
          armed = 1'b0;
          if (sb_q.size() == 0) begin
            chk("sb_underflow", 1, 0);
          end else begin
            mon_e = sb_q.pop_front();
            chk("sb_sample_cnt", sample_cnt, mon_e.cnt);
            chk("sb_err_cnt", err_cnt, mon_e.err);
            chk("sb_max_ed", max_ed, mon_e.mx);
            chk("sb_sum_ed", sum_ed, mon_e.sum32);
            chk("sb_sum_sat", sum_sat, mon_e.sat32);
            chk("sb_done17", done17, 1);
            chk("sb_sample_cnt17", sample_cnt17, mon_e.cnt);
            chk("sb_err_cnt17", err_cnt17, mon_e.err);
            chk("sb_max_ed17", max_ed17, mon_e.mx);
            chk("sb_sum_ed17", sum_ed17, mon_e.sum17);
            chk("sb_sum_sat17", sum_sat17, mon_e.sat17);
          end
        end
        if (start && !busy) armed = 1'b1;
      end
    end
  end

  // Caller is 1 time unit after a rising edge; returns at the same phase
  task automatic run(input int n, input bit gaps, input bit mid_start, input bit hold, input bit push);
    exp_t e;
    int   idx, it;
    bit   v, acc;
    if (push) begin
      e = model(n);
      sb_q.push_back(e);
    end
    start = 1'b1; n_samples = 16'(n);
    @(posedge clk); #1;
    start = 1'b0; n_samples = 16'($urandom);
    if (n == 0) begin
      chk("zero_done", done, 1);
      chk("zero_ready", in_ready, 0);
      in_valid = 1'b1;
      repeat (3) begin
        @(posedge clk); #1;
        chk("zero_ready_hold", in_ready, 0);
        chk("zero_cnt_hold", sample_cnt, 0);
      end
      in_valid = 1'b0;
      return;
    end
    idx = 0; it = 0;
    while (idx < n && it < n * 8 + 50) begin
      v        = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_valid = v;
      a        = 8'(sa[idx]);
      b        = 8'(sb[idx]);
      approx   = 16'(sap[idx]);
      start    = mid_start && (it == 1);
      if (start) n_samples = 16'($urandom_range(2, 60));
      acc      = v && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      it++;
    end
    start = 1'b0;
    chk("feed_count", idx, n);
    in_valid = hold;
    a = 8'($urandom); b = 8'($urandom); approx = 16'($urandom);
    chk("lat_done_0", done, 0);
    @(posedge clk); #1;
    chk("lat_done_1", done, 0);
    if (hold) chk("drain_ready", in_ready, 0);
    @(posedge clk); #1;
    chk("lat_done_2", done, 1);
    chk("lat_cnt", sample_cnt, n);
    if (hold) begin
      repeat (2) begin
        @(posedge clk); #1;
        chk("hold_cnt", sample_cnt, n);
        chk("hold_ready", in_ready, 0);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic fill_random(input int n);
    int p, d;
    for (int i = 0; i < n; i++) begin
      sa[i] = $urandom_range(0, 255);
      sb[i] = $urandom_range(0, 255);
      p     = sa[i] * sb[i];
      case ($urandom_range(0, 2))
        0: sap[i] = p;
        1: begin
          d = $urandom_range(0, 700);
          sap[i] = ($urandom_range(0, 1) != 0) ? p + d : p - d;
          if (sap[i] < 0) sap[i] = 0;
          if (sap[i] > 65535) sap[i] = 65535;
        end
        default: sap[i] = $urandom_range(0, 65535);
      endcase
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; n_samples = 16'd0;
    a = 8'd0; b = 8'd0; approx = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    sa[0] = 255; sb[0] = 255; sap[0] = 64512;
    run(1, 0, 0, 0, 1);
    chk("single_max_ed", max_ed, 513);
    chk("single_sum_ed", sum_ed, 513);

    sa[0] = 0;  sb[0] = 0;  sap[0] = 0;
    sa[1] = 16; sb[1] = 16; sap[1] = 256;
    sa[2] = 7;  sb[2] = 9;  sap[2] = 63;
    run(3, 0, 0, 0, 1);
    chk("exact_err_cnt", err_cnt, 0);

    run(0, 0, 0, 0, 1);

    fill_random(4);
    run(4, 0, 1, 1, 1);

    for (int i = 0; i < 3; i++) begin
      sa[i] = 255; sb[i] = 255; sap[i] = 0;
    end
    run(3, 0, 0, 0, 1);
    chk("sat17_flag", sum_sat17, 1);
    chk("sat17_sum", sum_ed17, 131071);
    chk("sat32_sum", sum_ed, 195075);

    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(1, 24);
      fill_random(n);
      run(n, 1, 0, 0, 1);
    end

    fill_random(5);
    start = 1'b1; n_samples = 16'd5;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; a = 8'(sa[i]); b = 8'(sb[i]); approx = 16'(sap[i]);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk_zero("abort");
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_ready", in_ready, 0);
    @(posedge clk); #1;
    chk("post_rst_idle", busy, 0);
    chk("post_rst_cnt", sample_cnt, 0);
    fill_random(3);
    run(3, 1, 0, 0, 1);

    repeat (2) @(posedge clk);
    #1;
    chk("sb_empty", sb_q.size(), 0);
    chk("monitor_idle", armed, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bam8_err_stats.md
BAM8_ERR_STATS -- requirements
Module: bam8_err_stats

Interface
REQ-001 SHALL have parameter SUM_W, default 32: width of the error-distance accumulator, legal range 17..48.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port start, input, 1: begin a measurement run.
REQ-005 SHALL have port n_samples, input, 16: run length, sampled on accepted start.
REQ-006 SHALL have port in_valid, input, 1: a, b and approx are valid.
REQ-007 SHALL have port in_ready, output, 1: block accepts a sample this cycle.
REQ-008 SHALL have ports a and b, input, 8 each: unsigned multiplier operands.
REQ-009 SHALL have port approx, input, 16: product from the 8x8 approximate multiplier under test.
REQ-010 SHALL have port busy, output, 1: run in progress (RUN or DRAIN).
REQ-011 SHALL have port done, output, 1: statistics final and stable.
REQ-012 SHALL have port sample_cnt, output, 16: samples accounted into statistics.
REQ-013 SHALL have port err_cnt, output, 16: samples with approx != a*b.
REQ-014 SHALL have port max_ed, output, 16: largest error distance seen.
REQ-015 SHALL have port sum_ed, output, SUM_W: sum of error distances.
REQ-016 SHALL have port sum_sat, output, 1: sum_ed has saturated.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DRAIN, DONE; busy = RUN or DRAIN; done = DONE.
REQ-018 In IDLE or DONE, start=1 SHALL clear all statistics outputs and sum_sat to 0, latch n_samples, and go to RUN; if n_samples=0, go to DONE instead.
REQ-019 start in RUN or DRAIN SHALL be ignored.
REQ-020 in_ready SHALL be 1 only in RUN; a sample is accepted when in_valid and in_ready are both 1.
REQ-021 RUN SHALL go to DRAIN in the cycle the n_samples-th sample is accepted.
REQ-022 DRAIN SHALL go to DONE once the pipeline is empty; DONE SHALL hold until start or rst.
REQ-023 Stage 1 SHALL register a, b and approx on acceptance, together with a valid bit.
REQ-024 Stage 2 SHALL compute the exact 16-bit product a*b from the stage-1 registers.
REQ-025 Stage 2 SHALL compute ed = |exact - approx| with 17-bit signed intermediate arithmetic; ed SHALL fit in 16 bits.
REQ-026 Stage 2 SHALL register ed, an error flag (ed != 0) and a valid bit.
REQ-027 Stage 3 SHALL update on stage-2 valid:
  - sample_cnt += 1
  - err_cnt += error flag
  - max_ed = max(max_ed, ed)
  - sum_ed += ed
REQ-028 Latency SHALL be fixed: a sample accepted in cycle t is reflected in the outputs after the edge ending cycle t+2.
REQ-029 Throughput SHALL be one sample per cycle with no bubbles while in_valid stays high.
REQ-030 When sum_ed + ed exceeds 2^SUM_W-1, sum_ed SHALL hold at 2^SUM_W-1 and sum_sat SHALL set and stay set until the next accepted start.
REQ-031 The block SHALL ignore in_valid=1 while in_ready=0, with no state change and no sample counted.
REQ-032 The DRAIN-to-DONE transition SHALL occur in the same cycle in which the last sample reaches the statistics, so that done=1 coincides with sample_cnt = n_samples.

Reset
REQ-033 rst=1 SHALL asynchronously force:
  - state to IDLE
  - all pipeline valid bits to 0
  - every output to 0, including in_ready, busy, done and sum_sat
REQ-034 rst asserted mid-run SHALL discard the in-flight samples, and the first cycle after release SHALL be IDLE.

Verification
REQ-035 SHALL check: start with n_samples=1, then a=255, b=255, approx=64512 -> after 2 cycles, sample_cnt=1, err_cnt=1, max_ed=513, sum_ed=513, done=1.
REQ-036 SHALL check: n_samples=3, back-to-back exact samples (0,0,0), (16,16,256), (7,9,63) -> err_cnt=0, sum_ed=0, sample_cnt=3, done 2 cycles after the last accept.
REQ-037 SHALL check: start with n_samples=0 -> done=1 the next cycle, all counters 0, in_ready never 1.
REQ-038 SHALL check: start pulsed during RUN, plus in_valid held high after the n-th accept -> run unchanged, no extra sample counted.
REQ-039 SHALL check: SUM_W=17 with repeated approx=0, a=b=255 (ed=65025) -> sum_sat=1 and sum_ed=131071 after the third sample.
REQ-040 SHALL check: rst asserted with 2 samples in flight -> all outputs 0 immediately; a new start yields stats from post-reset samples only.
